// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: default sizing for the block grid and worker pool,
// plus the dispatcher state encoding.
package coproc_pkg;

  localparam int NUM_CU_DEF      = 4;
  localparam int NUM_CU_LOG_DEF  = 2;
  localparam int INDEX_WIDTH_DEF = 8;
  localparam int MAX_MU_LOG_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_OFFER,
    ST_DRAIN,
    ST_DONE
  } disp_state_t;

endpackage

// File: rtl/rr_free_select.sv
// Round-robin search for the first non-busy requester starting at ptr (ptr < N).
// Purely combinational, zero latency; found=0 when every requester is busy.
module rr_free_select
  import coproc_pkg::*;
#(
  parameter int N     = NUM_CU_DEF,
  parameter int N_LOG = NUM_CU_LOG_DEF
) (
  input  logic [N-1:0]     busy,
  input  logic [N_LOG-1:0] ptr,
  output logic             found,
  output logic [N_LOG-1:0] idx
);

  logic [N_LOG:0] sum;

  // Walk the offsets from farthest to nearest so the nearest free slot wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (N_LOG + 1)'(k);
      if (sum >= (N_LOG + 1)'(N)) sum = sum - (N_LOG + 1)'(N);
      if (!busy[sum[N_LOG-1:0]]) begin
        found = 1'b1;
        idx   = sum[N_LOG-1:0];
      end
    end
  end

endmodule

// File: rtl/job_dispatcher.sv
// Hands every (i, j) block of a mu x mu grid to a free worker, one offer at a time,
// then waits for all completions; offers are held until the worker acknowledges.
module job_dispatcher
  import coproc_pkg::*;
#(
  parameter int NUM_CU      = NUM_CU_DEF,
  parameter int NUM_CU_LOG  = NUM_CU_LOG_DEF,
  parameter int index_width = INDEX_WIDTH_DEF,
  parameter int max_mu_log  = MAX_MU_LOG_DEF
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Start,
  input  logic [max_mu_log-1:0]         i_mu,
  output logic [max_mu_log-1:0]         o_mu,
  output logic                          o_Busy,
  output logic                          o_Done,
  output logic [NUM_CU*index_width-1:0] o_Row_Index,
  output logic [NUM_CU*index_width-1:0] o_Column_Index,
  output logic [NUM_CU-1:0]             o_Indexes_Ready,
  input  logic [NUM_CU-1:0]             i_Indexes_Received,
  input  logic [NUM_CU-1:0]             i_Result_Ready
);

  localparam int CW = 2 * max_mu_log;

  disp_state_t state, state_nxt;

  logic [max_mu_log-1:0]                 mu_q;
  logic [index_width-1:0]                r_i, r_j;
  logic [CW-1:0]                         r_issued, r_completed, mu_sq, n_done;
  logic [NUM_CU-1:0]                     r_busy_cu, r_result_prev, ready_q;
  logic [NUM_CU-1:0]                     ack_mask, rise;
  logic [NUM_CU_LOG-1:0]                 r_ptr, sel_q, free_idx, ptr_nxt;
  logic [NUM_CU-1:0][index_width-1:0]    row_q, col_q;
  logic                                  free_found, start_acc, offer_go, ack, last_col;

  assign mu_sq    = CW'(mu_q) * CW'(mu_q);
  assign last_col = (r_j == (index_width'(mu_q) - index_width'(1)));
  assign ptr_nxt  = (sel_q == NUM_CU_LOG'(NUM_CU - 1)) ? '0 : sel_q + NUM_CU_LOG'(1);

  assign o_mu            = mu_q;
  assign o_Indexes_Ready = ready_q;
  assign o_Row_Index     = row_q;
  assign o_Column_Index  = col_q;

  rr_free_select #(
    .N     (NUM_CU),
    .N_LOG (NUM_CU_LOG)
  ) u_free_select (
    .busy  (r_busy_cu),
    .ptr   (r_ptr),
    .found (free_found),
    .idx   (free_idx)
  );

  always_comb begin
    start_acc = i_Start && (state == ST_IDLE || state == ST_DONE);
    offer_go  = (state == ST_SELECT) && free_found;
    ack       = (state == ST_OFFER) && i_Indexes_Received[sel_q];
    ack_mask  = '0;
    if (ack) ack_mask[sel_q] = 1'b1;
    // A worker being acknowledged this cycle cannot also complete this cycle.
    rise = i_Result_Ready & ~r_result_prev & r_busy_cu & ~ack_mask;
    if (state == ST_IDLE) rise = '0;
    n_done = '0;
    for (int n = 0; n < NUM_CU; n++) n_done = n_done + CW'(rise[n]);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_Busy    = 1'b0;
    o_Done    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        o_Done = (state == ST_DONE);
        if (i_Start) state_nxt = (i_mu == '0) ? ST_DONE : ST_SELECT;
      end
      ST_SELECT: begin
        o_Busy = 1'b1;
        if (free_found) state_nxt = ST_OFFER;
      end
      ST_OFFER: begin
        o_Busy = 1'b1;
        if (ack) state_nxt = ((r_issued + CW'(1)) == mu_sq) ? ST_DRAIN : ST_SELECT;
      end
      ST_DRAIN: begin
        o_Busy = 1'b1;
        if (r_completed == mu_sq) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      mu_q          <= '0;
      r_i           <= '0;
      r_j           <= '0;
      r_issued      <= '0;
      r_completed   <= '0;
      r_busy_cu     <= '0;
      r_result_prev <= '0;
      ready_q       <= '0;
      r_ptr         <= '0;
      sel_q         <= '0;
      row_q         <= '0;
      col_q         <= '0;
    end else begin
      r_result_prev <= i_Result_Ready;
      r_busy_cu     <= (r_busy_cu & ~rise) | ack_mask;
      r_completed   <= r_completed + n_done;
      if (start_acc) begin
        mu_q        <= i_mu;
        r_i         <= '0;
        r_j         <= '0;
        r_issued    <= '0;
        r_completed <= '0;
      end
      if (offer_go) begin
        sel_q             <= free_idx;
        ready_q[free_idx] <= 1'b1;
        row_q[free_idx]   <= r_i;
        col_q[free_idx]   <= r_j;
      end
      if (ack) begin
        ready_q[sel_q] <= 1'b0;
        r_issued       <= r_issued + CW'(1);
        r_ptr          <= ptr_nxt;
        if (last_col) begin
          r_j <= '0;
          r_i <= r_i + index_width'(1);
        end else begin
          r_j <= r_j + index_width'(1);
        end
      end
    end
  end

endmodule

// File: doc/job_dispatcher.md
# job_dispatcher

Top-level work distributor for the coprocessor's matrix-multiply array. It enumerates every output block C_ij of a mu×mu block grid and hands each (i, j) pair to a free worker control unit over the Indexes_Ready / Indexes_Received handshake. It then tracks each worker's completion through Result_Ready and raises o_Done once all mu² blocks have been written back. It sits between the host-facing start/status logic and the NUM_CU worker control units.

## Interface
- NUM_CU, 4: number of worker control units served.
- NUM_CU_LOG, 2: ceil(log2(NUM_CU)), minimum 1.
- index_width, 8: width of a block row/column index.
- max_mu_log, 8: width of mu; must satisfy max_mu_log ≤ index_width.

Ports:
- i_Clock  in  1  single clock; all logic on posedge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Start  in  1  start a job; sampled only in IDLE.
- i_mu  in  max_mu_log  grid dimension in blocks; latched on an accepted i_Start.
- o_mu  out  max_mu_log  latched mu, broadcast to all workers.
- o_Busy  out  1  high from the accepted start until DONE.
- o_Done  out  1  high in DONE; held until the next accepted i_Start.
- o_Row_Index  out  NUM_CU*index_width  per-worker i, slice n = bits [n*index_width +: index_width].
- o_Column_Index  out  NUM_CU*index_width  per-worker j, same slicing.
- o_Indexes_Ready  out  NUM_CU  per-worker offer-valid.
- i_Indexes_Received  in  NUM_CU  per-worker acknowledge.
- i_Result_Ready  in  NUM_CU  per-worker block-finished level.

## Operation
- State encoding: IDLE, SELECT, OFFER, DRAIN, DONE.
- Registers:
  - r_i, r_j: next block to issue, each index_width wide.
  - r_Issued and r_Completed: 2*max_mu_log wide.
  - r_Busy_CU[NUM_CU]: per-worker busy flags.
  - r_Result_Prev[NUM_CU]: previous-cycle copy of i_Result_Ready, for edge detection.
  - r_Ptr: NUM_CU_LOG wide, round-robin pointer.
- IDLE:
  - i_Start=1 latches mu, clears r_i, r_j and both counters, clears o_Done and sets o_Busy.
  - Go to DONE if mu=0, otherwise go to SELECT.
- SELECT:
  - Pick the first worker n with r_Busy_CU[n]=0, searching cyclically from r_Ptr.
  - If one exists: drive o_Row_Index[n]=r_i, o_Column_Index[n]=r_j, set o_Indexes_Ready[n]=1, and go to OFFER.
  - If none exists: stay in SELECT.
- OFFER:
  - Hold o_Indexes_Ready[n] and the index slices stable until i_Indexes_Received[n]=1 is sampled.
  - On that edge: clear o_Indexes_Ready[n], set r_Busy_CU[n], increment r_Issued, and set r_Ptr=n+1 (modulo NUM_CU).
  - On the same edge, advance row-major: r_j+1, wrapping to 0 at mu-1 with r_i+1.
  - Next state: DRAIN if r_Issued+1 = mu², otherwise SELECT.
- Completion runs in every state except IDLE:
  - A rising edge of i_Result_Ready[n] (current=1, r_Result_Prev=0) while r_Busy_CU[n]=1 clears r_Busy_CU[n] and increments r_Completed.
  - Rising edges on non-busy workers are ignored.
  - Multiple simultaneous completions are all counted in the same cycle (popcount add).
- DRAIN: when r_Completed reaches mu², go to DONE.
- DONE: o_Done=1 and o_Busy=0. i_Start behaves as in IDLE, so DONE doubles as the idle state after the first job.
- Acknowledge and completion on the same worker in the same cycle: the acknowledge sets busy, and the completion is ignored for that cycle.
- o_Indexes_Received levels outside OFFER are ignored.
- Only one offer is outstanding at a time.

## Timing
- Reset values:
  - State=IDLE; every counter, flag and pointer is 0.
  - o_Busy=0, o_Done=0, o_Indexes_Ready=0, o_mu=0, all index slices 0.
- i_Start sampled at edge t: o_Busy=1 from t+1. With a free worker, o_Indexes_Ready[n] rises at edge t+2 (SELECT at t+1 registers the offer).
- Acknowledge sampled at edge a: o_Indexes_Ready falls at a+1. The next offer rises no earlier than a+2.
- Minimum issue interval: 2 cycles per block with acknowledge-in-same-cycle.
- o_Done rises one edge after the cycle in which r_Completed reaches mu².
- Reset asserted mid-job returns everything to reset values on the next edge. Outstanding worker jobs are abandoned and the workers are not notified.
- i_Start is ignored whenever o_Busy=1.

## Structure
- Shared package coproc_pkg holds:
  - the state enumeration localparams,
  - the index_width and max_mu_log defaults,
  - NUM_CU.
- Sub-module rr_free_select:
  - Inputs: busy vector, pointer.
  - Outputs: found flag and selected index.
  - Combinational, and reused by the memory arbiter.

## Test plan
- Reset, then mu=1 with worker 0 acknowledging immediately: Ready[0] with (0,0). After Result_Ready pulses, o_Done=1 and Busy=0 exactly one edge after completion.
- mu=2, NUM_CU=4, all workers acknowledging in one cycle: offers go to workers 0,1,2,3 with (0,0),(0,1),(1,0),(1,1) respectively. Done after the 4th completion.
- mu=3 with only 2 workers ever completing: the dispatcher stalls in SELECT with no Ready until a worker completes. Row-major order is preserved and all 9 blocks are issued exactly once.
- Delayed acknowledge of 5 cycles: Ready and indexes stay constant for 5 cycles, then Ready drops one cycle after the acknowledge.
- Two workers raise Result_Ready on the same edge: r_Completed increases by 2. A level held high does not re-count.
- mu=0, then reset asserted mid-job (after 3 blocks issued with mu=4):
  - mu=0 gives immediate Done.
  - The reset returns all outputs to 0.
  - A following start with mu=1 runs cleanly.
